// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    REDIR = 2'd2,
    FAULT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SEL_SEQ   = 2'd0,
    SEL_PCREL = 2'd1,
    SEL_JALR  = 2'd2
  } sel_t;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/pc_sequencer_target.sv
// PC-relative target adder shared by branches and jal.
module pc_sequencer_target (
  input  logic [31:0] i_pc,
  input  logic [31:0] i_imm,
  output logic [31:0] o_target
);

  assign o_target = i_pc + i_imm;

endmodule

// File: rtl/pc_sequencer.sv
// Owns the fetch PC: sequential advance, branch/jal/jalr redirect with a
// one-cycle flush bubble, and a sticky fault on misaligned targets.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR_P = RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        fetch_ready,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        jalr,
  input  logic [31:0] imm_ext,
  input  logic [31:0] rs1_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] pc_target,
  output logic        fetch_valid,
  output logic        flush,
  output logic        fault
);

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  sel_t        w_sel;
  logic [31:0] w_jalr_target;
  logic [31:0] w_xfer_target;
  logic        w_misaligned;
  logic        w_advance;

  pc_sequencer_target u_target (
    .i_pc     (r_pc),
    .i_imm    (imm_ext),
    .o_target (pc_target)
  );

  assign pc            = r_pc;
  assign pc_plus4      = r_pc + 32'd4;
  assign w_jalr_target = (rs1_data + imm_ext) & ~32'h1;

  // Moore outputs decoded from the registered state only.
  assign fetch_valid = (r_state == RUN);
  assign flush       = (r_state == REDIR);
  assign fault       = (r_state == FAULT);
  assign w_advance   = fetch_valid & fetch_ready & ~stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= BOOT;
      r_pc    <= RESET_VECTOR_P;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  always_comb begin
    w_sel         = SEL_SEQ;
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    if (jalr) begin
      w_sel = SEL_JALR;
    end else if (jump || branch_taken) begin
      w_sel = SEL_PCREL;
    end
    w_xfer_target = (w_sel == SEL_JALR) ? w_jalr_target : pc_target;
    // jalr already has bit 0 cleared, so only bit 1 can trip it there.
    w_misaligned  = (w_xfer_target[1:0] != 2'b00);

    case (r_state)
      BOOT: begin
        w_state_next = RUN;
        w_pc_next    = RESET_VECTOR_P;
      end
      RUN: begin
        if (w_advance) begin
          if (w_sel == SEL_SEQ) begin
            w_pc_next = pc_plus4;
          end else if (w_misaligned) begin
            w_state_next = FAULT;
          end else begin
            w_pc_next    = w_xfer_target;
            w_state_next = REDIR;
          end
        end
      end
      REDIR:   w_state_next = RUN;
      FAULT:   w_state_next = FAULT;
      default: w_state_next = BOOT;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench: directed test-plan scenarios plus randomized traffic,
// all checked each cycle against a behavioural model of the sequencer.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        fetch_ready = 1'b1;
  logic        branch_taken = 1'b0;
  logic        jump = 1'b0;
  logic        jalr = 1'b0;
  logic [31:0] imm_ext = 32'h0;
  logic [31:0] rs1_data = 32'h0;
  logic [31:0] pc, pc_plus4, pc_target;
  logic        fetch_valid, flush, fault;

  int n_cmp = 0;
  int n_mis = 0;

  // Model: mode 0 = booting, 1 = running, 2 = bubble after transfer, 3 = faulted
  int          m_mode = 0;
  logic [31:0] m_pc   = 32'h0;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .fetch_ready(fetch_ready),
    .branch_taken(branch_taken), .jump(jump), .jalr(jalr),
    .imm_ext(imm_ext), .rs1_data(rs1_data), .pc(pc), .pc_plus4(pc_plus4),
    .pc_target(pc_target), .fetch_valid(fetch_valid), .flush(flush), .fault(fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= 0;
      m_pc   <= 32'h0;
    end else begin
      case (m_mode)
        0: m_mode <= 1;
        1: if (fetch_ready && !stall) begin
             logic [31:0] t;
             logic        x;
             x = 1'b1;
             if (jalr)                     t = (rs1_data + imm_ext) & 32'hFFFF_FFFE;
             else if (jump || branch_taken) t = m_pc + imm_ext;
             else begin x = 1'b0; t = m_pc + 32'd4; end
             if (!x)             m_pc <= t;
             else if (t % 4 != 0) m_mode <= 3;
             else begin m_pc <= t; m_mode <= 2; end
           end
        2: m_mode <= 1;
        default: m_mode <= 3;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("pc",          pc,          m_pc);
      check("pc_plus4",    pc_plus4,    m_pc + 32'd4);
      check("pc_target",   pc_target,   m_pc + imm_ext);
      check("fetch_valid", {31'b0, fetch_valid}, {31'b0, m_mode == 1});
      check("flush",       {31'b0, flush},       {31'b0, m_mode == 2});
      check("fault",       {31'b0, fault},       {31'b0, m_mode == 3});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    branch_taken = 0; jump = 0; jalr = 0; stall = 0; fetch_ready = 1;
  endtask

  // Redirect through an aligned jalr so a scenario can start at any address.
  task automatic goto(input logic [31:0] addr);
    int n;
    clear_ctl();
    n = 0;
    while (!fetch_valid && n < 5) begin step(); n++; end
    if (!fetch_valid) begin
      n_cmp++; n_mis++;
      $display("FAIL goto_timeout: fetch_valid=%b expected 1", fetch_valid);
    end
    jalr = 1; rs1_data = addr; imm_ext = 0;
    step();
    clear_ctl();
    step();
  endtask

  initial begin
    clear_ctl();
    rst = 1;
    #2;
    check("rst_pc", pc, 32'h0);
    check("rst_fv", {31'b0, fetch_valid}, 32'h0);
    check("rst_fault", {31'b0, fault}, 32'h0);
    step(); step();
    rst = 0;
    check("boot_fv", {31'b0, fetch_valid}, 32'h0);
    step();
    check("run_fv", {31'b0, fetch_valid}, 32'h1);
    check("seq0", pc, 32'h0);
    step(); check("seq4", pc, 32'h4);
    step(); check("seq8", pc, 32'h8);
    step(); check("seqC", pc, 32'hC);
    step(); check("seq10", pc, 32'h10);
    $display("txn seq: pc 0x0..0x10");

    branch_taken = 1; imm_ext = 32'h14;
    step(); clear_ctl();
    check("br_pc", pc, 32'h24);
    check("br_flush", {31'b0, flush}, 32'h1);
    check("br_fv", {31'b0, fetch_valid}, 32'h0);
    step();
    check("br_fv2", {31'b0, fetch_valid}, 32'h1);
    check("br_pc2", pc, 32'h24);
    $display("txn branch: 0x10 -> 0x24");

    goto(32'h20);
    check("goto20", pc, 32'h20);
    jump = 1; jalr = 1; rs1_data = 32'h101; imm_ext = 32'h54;
    step(); clear_ctl(); step();
    check("jalr_pc", pc, 32'h154);
    $display("txn jalr+jump: 0x20 -> 0x154");

    goto(32'h10450);
    branch_taken = 1; imm_ext = 32'h10; stall = 1;
    repeat (3) begin
      step();
      check("stall_pc", pc, 32'h10450);
      check("stall_flush", {31'b0, flush}, 32'h0);
    end
    stall = 0; fetch_ready = 0;
    repeat (3) begin
      step();
      check("nrdy_pc", pc, 32'h10450);
      check("nrdy_flush", {31'b0, flush}, 32'h0);
    end
    fetch_ready = 1;
    step(); clear_ctl();
    check("rel_pc", pc, 32'h10460);
    check("rel_flush", {31'b0, flush}, 32'h1);
    step();
    $display("txn hold/release: 0x10450 -> 0x10460");

    goto(32'hFFFF_FFFC);
    step();
    check("wrap_pc", pc, 32'h0);
    check("wrap_fault", {31'b0, fault}, 32'h0);
    $display("txn wrap: 0xFFFFFFFC -> 0x0");

    goto(32'h8);
    branch_taken = 1; imm_ext = 32'h6;
    step(); clear_ctl();
    check("mis_fault", {31'b0, fault}, 32'h1);
    check("mis_pc", pc, 32'h8);
    check("mis_fv", {31'b0, fetch_valid}, 32'h0);
    jump = 1; imm_ext = 32'h40;
    repeat (3) step();
    check("mis_sticky", {31'b0, fault}, 32'h1);
    check("mis_frozen", pc, 32'h8);
    clear_ctl();
    #3 rst = 1;
    #1;
    check("async_fault", {31'b0, fault}, 32'h0);
    check("async_pc", pc, 32'h0);
    step();
    rst = 0;
    $display("txn misaligned: fault at 0x8, cleared by rst");

    for (int i = 0; i < 2000; i++) begin
      stall        = ($urandom_range(0, 3) == 0);
      fetch_ready  = ($urandom_range(0, 4) != 0);
      branch_taken = ($urandom_range(0, 5) == 0);
      jump         = ($urandom_range(0, 9) == 0);
      jalr         = ($urandom_range(0, 9) == 0);
      imm_ext      = $urandom & 32'hFFFF_FFFC;
      rs1_data     = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) imm_ext[1:0] = 2'($urandom);
      if ($urandom_range(0, 15) == 0) rs1_data[1:0] = 2'($urandom);
      if (m_mode == 3 && $urandom_range(0, 3) == 0) begin
        rst = 1; step(); rst = 0;
      end else begin
        step();
      end
    end
    $display("txn random: 2000 cycles");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
